pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_if.sv | 29 ++
 rtl/pipelined_adder.sv | 112 +++++++++++
 tb/tb_pipelined_adder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - Valid/ready operand and result bundle for pipelined_adder
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SUM;
    logic             Cout;
    logic             OVF;
    logic             ZERO;

    // Producer of operands and consumer of results
    modport master (
        output in_valid, A, B, Cin, SUB, out_ready,
        input  in_ready, out_valid, SUM, Cout, OVF, ZERO
    );

    // The adder itself
    modport slave (
        input  in_valid, A, B, Cin, SUB, out_ready,
        output in_ready, out_valid, SUM, Cout, OVF, ZERO
    );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - Slice-pipelined WIDTH-bit adder/subtractor with valid/ready flow control
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    pipelined_adder_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH/STAGES combination is not supported");
    end

    logic w_adv;

    // The whole pipe moves as one unless a finished result is waiting on the consumer.
    assign w_adv        = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    // Stage k adds slice k. Operand registers shrink by SW each stage (only the
    // bits still to be added travel on), while the sum register grows by SW
    // (finished low slices travel with the token).
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * SW;   // operand bits not yet added
        localparam int OW = (k + 1) * SW;     // sum bits finished after this stage

        logic [IW-1:0] w_a;
        logic [IW-1:0] w_b;
        logic          w_cin;
        logic          w_vld;
        logic [SW:0]   w_slice;
        logic [OW-1:0] w_s;

        logic          r_vld;
        logic [OW-1:0] r_s;
        logic          r_c;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + 1; Cin is ignored in that mode.
            assign w_a   = bus.A;
            assign w_b   = bus.SUB ? ~bus.B : bus.B;
            assign w_cin = bus.SUB | bus.Cin;
            assign w_vld = bus.in_valid;
            assign w_s   = w_slice[SW-1:0];
        end else begin : g_body
            assign w_a   = g_stage[k-1].g_fwd.r_a;
            assign w_b   = g_stage[k-1].g_fwd.r_b;
            assign w_cin = g_stage[k-1].r_c;
            assign w_vld = g_stage[k-1].r_vld;
            assign w_s   = {w_slice[SW-1:0], g_stage[k-1].r_s};
        end

        assign w_slice = {1'b0, w_a[SW-1:0]} + {1'b0, w_b[SW-1:0]} + {{SW{1'b0}}, w_cin};

        // Token valid bit, finished sum bits and carry into the next slice
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_vld <= 1'b0;
                r_s   <= '0;
                r_c   <= 1'b0;
            end else if (w_adv) begin
                r_vld <= w_vld;
                r_s   <= w_s;
                r_c   <= w_slice[SW];
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IW-SW-1:0] r_a;
            logic [IW-SW-1:0] r_b;

            // Carry the still-unadded upper operand bits along with the token
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[IW-1:SW];
                    r_b <= w_b[IW-1:SW];
                end
            end
        end else begin : g_tail
            logic w_ovf;
            logic w_zero;
            logic r_ovf;
            logic r_zero;

            // Carry into the MSB is a^b^sum at that bit; overflow is that XOR carry out.
            assign w_ovf  = w_a[SW-1] ^ w_b[SW-1] ^ w_slice[SW-1] ^ w_slice[SW];
            assign w_zero = (w_s == '0);

            // Status flags registered alongside the final sum slice
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_adv) begin
                    r_ovf  <= w_ovf;
                    r_zero <= w_zero;
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].r_vld;
    assign bus.SUM       = g_stage[STAGES-1].r_s;
    assign bus.Cout      = g_stage[STAGES-1].r_c;
    assign bus.OVF       = g_stage[STAGES-1].g_tail.r_ovf;
    assign bus.ZERO      = g_stage[STAGES-1].g_tail.r_zero;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - Scoreboard bench for pipelined_adder (32/4 and 8/8 instances)
module tb_pipelined_adder;
    typedef logic [34:0] res_t;   // {ZERO, OVF, Cout, SUM[31:0]}

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    res_t q[$];
    res_t q8[$];

    logic acc, fire, irdy, ovld, he;
    res_t obs, ex;

    pipelined_adder_if #(.WIDTH(32)) bus ();
    pipelined_adder_if #(.WIDTH(8))  bus8 ();

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
    pipelined_adder #(.WIDTH(8),  .STAGES(8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));

    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input int w);
        logic [32:0] m, full;
        logic [31:0] bb, s;
        logic co, ov;
        m    = (33'd1 << w) - 33'd1;
        bb   = sub ? ~b : b;
        full = ({1'b0, a} & m) + ({1'b0, bb} & m) + {32'd0, (sub | cin)};
        co   = full[w];
        s    = full[31:0] & m[31:0];
        ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
        return {(s == 32'd0), ov, co, s};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(7, 0))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic ordy);
        @(negedge clk);
        bus.in_valid = v; bus.A = a; bus.B = b; bus.Cin = cin; bus.SUB = sub;
        bus.out_ready = ordy;
        #1;
        irdy = bus.in_ready;
        ovld = bus.out_valid;
        acc  = v && irdy;
        fire = ovld && ordy;
        obs  = {bus.ZERO, bus.OVF, bus.Cout, bus.SUM};
        he   = 1'b0;
        ex   = '0;
        if (fire && q.size() > 0) begin he = 1'b1; ex = q.pop_front(); end
        if (acc) q.push_back(model(a, b, cin, sub, 32));
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.SUM !== 32'd0) begin n_err++; $display("FAIL rst_sum got %h want 0", bus.SUM); end
        n_vec++; if ({bus.Cout, bus.OVF, bus.ZERO} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {bus.Cout, bus.OVF, bus.ZERO}); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        n_vec++; if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid8 got %b want 0", bus8.out_valid); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta[3];
        logic [31:0] tbv[3];
        logic        ts[3];
        res_t        tx[3];
        bit          got;
        ta[0] = 32'hFFFF_FFFF; tbv[0] = 32'h1; ts[0] = 1'b0; tx[0] = {1'b1, 1'b0, 1'b1, 32'h0000_0000};
        ta[1] = 32'h7FFF_FFFF; tbv[1] = 32'h1; ts[1] = 1'b0; tx[1] = {1'b0, 1'b1, 1'b0, 32'h8000_0000};
        ta[2] = 32'h0000_0005; tbv[2] = 32'h7; ts[2] = 1'b1; tx[2] = {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ta[i], tbv[i], 1'b0, ts[i], 1'b1);
            got = 1'b0;
            for (int c = 1; c <= 12 && !got; c++) begin
                drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
                if (fire) begin
                    got = 1'b1;
                    n_vec++; if (obs !== tx[i]) begin n_err++; $display("FAIL directed_%0d got %h want %h", i, obs, tx[i]); end
                    n_vec++; if (c != 4) begin n_err++; $display("FAIL directed_latency_%0d got %0d want 4", i, c); end
                end
            end
            if (!got) begin n_vec++; n_err++; $display("FAIL directed_timeout_%0d got none want result", i); end
        end
    endtask

    task automatic test_back_to_back();
        int first, last, cnt;
        first = -1; last = -1; cnt = 0;
        for (int c = 0; c < 30; c++) begin
            drive(c < 8, pick(), pick(), 1'($urandom_range(1, 0)), 1'(c % 2), 1'b1);
            if (c < 8) begin
                n_vec++; if (!acc) begin n_err++; $display("FAIL b2b_accept_%0d got 0 want 1", c); end
            end
            if (fire) begin
                n_vec++;
                if (!he) begin n_err++; $display("FAIL b2b_extra got %h want none", obs); end
                else if (obs !== ex) begin n_err++; $display("FAIL b2b_result got %h want %h", obs, ex); end
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
        end
        n_vec++; if (cnt != 8) begin n_err++; $display("FAIL b2b_count got %0d want 8", cnt); end
        n_vec++; if (first != 4) begin n_err++; $display("FAIL b2b_first got %0d want 4", first); end
        n_vec++; if (last - first != 7) begin n_err++; $display("FAIL b2b_span got %0d want 7", last - first); end
    endtask

    task automatic test_stall();
        logic [31:0] pa, pb;
        logic pc, ps, st;
        res_t snap;
        int sent, got;
        pa = pick(); pb = pick(); pc = 1'b1; ps = 1'b0;
        sent = 0; got = 0; snap = '0;
        for (int c = 0; c < 60 && (sent < 10 || got < 10); c++) begin
            st = (c >= 4 && c < 7);
            drive(sent < 10, pa, pb, pc, ps, !st);
            if (acc) begin
                sent++; pa = pick(); pb = pick();
                pc = 1'($urandom_range(1, 0)); ps = 1'($urandom_range(1, 0));
            end
            if (st) begin
                n_vec++; if (irdy !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_%0d got %b want 0", c, irdy); end
                n_vec++; if (ovld !== 1'b1) begin n_err++; $display("FAIL stall_out_valid_%0d got %b want 1", c, ovld); end
                if (c == 4) snap = obs;
                else begin
                    n_vec++; if (obs !== snap) begin n_err++; $display("FAIL stall_hold_%0d got %h want %h", c, obs, snap); end
                end
            end
            if (fire) begin
                n_vec++;
                if (!he) begin n_err++; $display("FAIL stall_extra got %h want none", obs); end
                else if (obs !== ex) begin n_err++; $display("FAIL stall_result got %h want %h", obs, ex); end
                got++;
            end
        end
        n_vec++; if (got != 10 || q.size() != 0) begin n_err++; $display("FAIL stall_drain got %0d/%0d want 10/0", got, q.size()); end
    endtask

    task automatic test_reset_mid();
        int cnt, lat;
        for (int c = 0; c < 5; c++) drive(1'b1, pick(), pick(), 1'b0, 1'(c % 2), 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.A = 32'h1234_5678; bus.B = 32'h1; bus.out_ready = 1'b1;
        #1;
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid got %b want 1", bus.out_valid); end
        #1 reset_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
        n_vec++; if ({bus.ZERO, bus.OVF, bus.Cout, bus.SUM} !== 35'd0) begin n_err++; $display("FAIL midrst_outputs got %h want 0", {bus.ZERO, bus.OVF, bus.Cout, bus.SUM}); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
        q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_accept got %b want 0", bus.out_valid); end
        drive(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 1'b1);
        cnt = 0; lat = -1;
        for (int c = 1; c <= 12; c++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            if (fire) begin
                cnt++;
                if (lat < 0) lat = c;
                n_vec++; if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_0031}) begin n_err++; $display("FAIL midrst_result got %h want 000000031", obs); end
            end
        end
        n_vec++; if (cnt != 1) begin n_err++; $display("FAIL midrst_count got %0d want 1", cnt); end
        n_vec++; if (lat != 4) begin n_err++; $display("FAIL midrst_latency got %0d want 4", lat); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(3, 0) != 0, pick(), pick(), 1'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)), $urandom_range(9, 0) < 7);
            if (fire) begin
                n_vec++;
                if (!he) begin n_err++; $display("FAIL rand_extra got %h want none", obs); end
                else if (obs !== ex) begin n_err++; $display("FAIL rand_result got %h want %h", obs, ex); end
            end
        end
        for (int c = 0; c < 60 && q.size() > 0; c++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            if (fire) begin
                n_vec++;
                if (!he || obs !== ex) begin n_err++; $display("FAIL rand_drain got %h want %h", obs, ex); end
            end
        end
        n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL rand_lost got %0d want 0", q.size()); end
    endtask

    task automatic test_random_w8();
        logic [31:0] a, b;
        logic v, cin, sub, ordy;
        res_t o8, e8;
        for (int c = 0; c < 500; c++) begin
            v = (c < 440) && ($urandom_range(3, 0) != 0);
            a = {24'd0, pick()[7:0]}; b = {24'd0, 8'($urandom)};
            cin = 1'($urandom_range(1, 0)); sub = 1'($urandom_range(1, 0));
            ordy = (c >= 440) || ($urandom_range(9, 0) < 7);
            @(negedge clk);
            bus8.in_valid = v; bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.Cin = cin; bus8.SUB = sub;
            bus8.out_ready = ordy;
            #1;
            if (bus8.out_valid && ordy) begin
                n_vec++;
                o8 = {bus8.ZERO, bus8.OVF, bus8.Cout, 24'd0, bus8.SUM};
                if (q8.size() == 0) begin n_err++; $display("FAIL w8_extra got %h want none", o8); end
                else begin
                    e8 = q8.pop_front();
                    if (o8 !== e8) begin n_err++; $display("FAIL w8_result got %h want %h", o8, e8); end
                end
            end
            if (v && bus8.in_ready) q8.push_back(model(a, b, cin, sub, 8));
        end
        n_vec++; if (q8.size() != 0) begin n_err++; $display("FAIL w8_lost got %0d want 0", q8.size()); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.SUB = 1'b0; bus.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0; bus8.SUB = 1'b0; bus8.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        test_random_w8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
